// File: rtl/vga_sync_fifo.sv
// vga_sync_fifo: single-clock show-ahead FIFO between pixel/command producers
// and the VGA pipeline. Level count, almost-full/almost-empty thresholds,
// synchronous flush, and overflow/underflow protection.
// Optional sticky error flags (overflow/underflow) are built only when the
// macro VGA_FIFO_ERR_EN is defined.
//
// Handshake: a write is taken on a rising edge when we=1 and the FIFO is not
// full, or when it is full but a read is taken on the same edge. A read is
// taken when re=1 and the FIFO is not empty. There is no empty-FIFO bypass.
// Requests that are not taken are dropped silently. flush overrides both.
module vga_sync_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  we,
    input  logic [W-1:0]          data_in,
    input  logic                  re,
    output logic [W-1:0]          data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   level
`ifdef VGA_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    localparam logic [LW-1:0] LVL_ZERO = '0;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Status flags decode from the registered level only.
    assign fifo_empty   = (level == LVL_ZERO);
    assign fifo_full    = (level == LVL_FULL);
    assign almost_full  = (level >= LVL_AF);
    assign almost_empty = (level <= LVL_AE);

    // Acceptance: a full FIFO can still take a write if the head pops the same edge.
    assign wr_ok = we & (~fifo_full | re);
    assign rd_ok = re & ~fifo_empty;

    // Show-ahead head word, forced to zero when nothing is stored.
    assign data_out = fifo_empty ? '0 : mem[rd_ptr];

    // Storage array; deliberately not reset, contents are masked by level.
    always_ff @(posedge clk) begin
        if (!flush && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally; level tracks net accepted writes minus reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                level <= level + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                level <= level - 1'b1;
            end
        end
    end

`ifdef VGA_FIFO_ERR_EN
    // Sticky error flags: record dropped writes and ignored reads until flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && fifo_full && !re) begin
                overflow <= 1'b1;
            end
            if (re && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_fifo.sv
// tb_vga_sync_fifo: directed table of per-edge vectors plus hand-written
// asynchronous-reset sequence for vga_sync_fifo at default parameters.
// Error-flag checks are active when VGA_FIFO_ERR_EN is defined.
module tb_vga_sync_fifo;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          we;
    logic [W-1:0]  data_in;
    logic          re;
    logic [W-1:0]  data_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_full;
    logic          almost_empty;
    logic [2:0]    level;
`ifdef VGA_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    vga_sync_fifo #(
        .W(W), .DEPTH_LOG2(2), .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .we           (we),
        .data_in      (data_in),
        .re           (re),
        .data_out     (data_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef VGA_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One vector = inputs applied before an edge and outputs expected after it.
    // flg packs {fifo_empty, fifo_full, almost_full, almost_empty}.
    typedef struct {
        logic         flush;
        logic         we;
        logic         re;
        logic [31:0]  din;
        logic [2:0]   lvl;
        logic [3:0]   flg;
        logic [31:0]  dout;
        logic         ovf;
        logic         udf;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic w, input logic r, input logic [31:0] d,
                       input logic [2:0] l, input logic [3:0] fl, input logic [31:0] o,
                       input logic ov, input logic ud);
        vec_t v;
        v.flush = f; v.we = w; v.re = r; v.din = d;
        v.lvl = l; v.flg = fl; v.dout = o; v.ovf = ov; v.udf = ud;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] l, input logic [3:0] fl,
                                 input logic [31:0] o, input logic ov, input logic ud);
        check({tag, " level"}, 32'(level), 32'(l));
        check({tag, " flags"}, 32'({fifo_empty, fifo_full, almost_full, almost_empty}), 32'(fl));
        check({tag, " data_out"}, data_out, o);
`ifdef VGA_FIFO_ERR_EN
        check({tag, " overflow"}, 32'(overflow), 32'(ov));
        check({tag, " underflow"}, 32'(underflow), 32'(ud));
`else
        if (ov !== ud) begin end
`endif
    endtask

    task automatic drive(input logic f, input logic w, input logic r, input logic [31:0] d);
        flush = f; we = w; re = r; data_in = d;
    endtask

    initial begin
        // Fill and drain
        add(0,1,0,32'hA0, 3'd1, 4'b0001, 32'hA0, 0,0);
        add(0,1,0,32'hA1, 3'd2, 4'b0000, 32'hA0, 0,0);
        add(0,1,0,32'hA2, 3'd3, 4'b0010, 32'hA0, 0,0);
        add(0,1,0,32'hA3, 3'd4, 4'b0110, 32'hA0, 0,0);
        add(0,0,1,32'h00, 3'd3, 4'b0010, 32'hA1, 0,0);
        add(0,0,1,32'h00, 3'd2, 4'b0000, 32'hA2, 0,0);
        add(0,0,1,32'h00, 3'd1, 4'b0001, 32'hA3, 0,0);
        add(0,0,1,32'h00, 3'd0, 4'b1001, 32'h00, 0,0);
        // Refill, then overflow attempt
        add(0,1,0,32'hA0, 3'd1, 4'b0001, 32'hA0, 0,0);
        add(0,1,0,32'hA1, 3'd2, 4'b0000, 32'hA0, 0,0);
        add(0,1,0,32'hA2, 3'd3, 4'b0010, 32'hA0, 0,0);
        add(0,1,0,32'hA3, 3'd4, 4'b0110, 32'hA0, 0,0);
        add(0,1,0,32'hFF, 3'd4, 4'b0110, 32'hA0, 1,0);
        // Full with simultaneous write and read, pointers wrap
        add(0,1,1,32'hB0, 3'd4, 4'b0110, 32'hA1, 1,0);
        add(0,1,1,32'hB1, 3'd4, 4'b0110, 32'hA2, 1,0);
        add(0,1,1,32'hB2, 3'd4, 4'b0110, 32'hA3, 1,0);
        add(0,1,1,32'hB3, 3'd4, 4'b0110, 32'hB0, 1,0);
        add(0,1,1,32'hB4, 3'd4, 4'b0110, 32'hB1, 1,0);
        add(0,1,1,32'hB5, 3'd4, 4'b0110, 32'hB2, 1,0);
        add(0,0,1,32'h00, 3'd3, 4'b0010, 32'hB3, 1,0);
        add(0,0,1,32'h00, 3'd2, 4'b0000, 32'hB4, 1,0);
        add(0,0,1,32'h00, 3'd1, 4'b0001, 32'hB5, 1,0);
        add(0,0,1,32'h00, 3'd0, 4'b1001, 32'h00, 1,0);
        // Empty corner: ignored read, then write+read on empty
        add(0,0,1,32'h00, 3'd0, 4'b1001, 32'h00, 1,1);
        add(0,1,1,32'hC0, 3'd1, 4'b0001, 32'hC0, 1,1);
        add(0,1,0,32'hC1, 3'd2, 4'b0000, 32'hC0, 1,1);
        add(0,1,0,32'hC2, 3'd3, 4'b0010, 32'hC0, 1,1);
        // Flush with a write pending: write discarded, flags cleared
        add(1,1,0,32'hD0, 3'd0, 4'b1001, 32'h00, 0,0);
        add(0,1,0,32'hE0, 3'd1, 4'b0001, 32'hE0, 0,0);
        // Flush beats read; flush on empty does not raise underflow
        add(1,0,1,32'h00, 3'd0, 4'b1001, 32'h00, 0,0);
        add(1,0,1,32'h00, 3'd0, 4'b1001, 32'h00, 0,0);
        // Build level 3 ahead of async reset
        add(0,1,0,32'hF0, 3'd1, 4'b0001, 32'hF0, 0,0);
        add(0,1,0,32'hF1, 3'd2, 4'b0000, 32'hF0, 0,0);
        add(0,1,0,32'hF2, 3'd3, 4'b0010, 32'hF0, 0,0);

        // Reset state, no clock edge needed
        reset = 1'b0;
        drive(0, 0, 0, 32'h0);
        #2;
        check_outputs("reset", 3'd0, 4'b1001, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table: apply on the falling edge, sample 1 time unit after the rising edge
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].flush, vecs[i].we, vecs[i].re, vecs[i].din);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].flg,
                          vecs[i].dout, vecs[i].ovf, vecs[i].udf);
        end

        // Async reset between edges clears state immediately
        @(negedge clk);
        drive(0, 0, 0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_reset", 3'd0, 4'b1001, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_outputs("reset_held", 3'd0, 4'b1001, 32'h0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 0, 32'h11);
        @(posedge clk);
        #1;
        check_outputs("post_reset_wr", 3'd1, 4'b0001, 32'h11, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 32'h22);
        @(posedge clk);
        #1;
        check_outputs("post_reset_wr2", 3'd2, 4'b0000, 32'h11, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("post_reset_rd", 3'd1, 4'b0001, 32'h22, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
